// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: frame geometry, bit-timer sizing
// and the receive FSM state encoding.
package uart_pkg;

   localparam int UART_DATA_BITS        = 8;
   localparam int UART_MAX_CLKS_PER_BIT = 1024;
   localparam int UART_TIMER_W          = $clog2(UART_MAX_CLKS_PER_BIT);
   localparam int UART_IDX_W            = $clog2(UART_DATA_BITS);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_state_e;

   // Converts a cycle count into a bit-timer load value.
   function automatic logic [UART_TIMER_W-1:0] uart_timer_val(input int cycles);
      return UART_TIMER_W'(cycles);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial input, received-byte handshake and error pulses of the UART receiver.
interface uart_rx_if;
   import uart_pkg::*;

   logic                      rx;
   logic [UART_DATA_BITS-1:0] data;
   logic                      valid;
   logic                      ready;
   logic                      frame_err;
   logic                      overrun;

   modport master (
      input  rx,
      input  ready,
      output data,
      output valid,
      output frame_err,
      output overrun
   );

   modport slave (
      output rx,
      output ready,
      input  data,
      input  valid,
      input  frame_err,
      input  overrun
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer: loads a value, counts to zero and holds there;
// expire_o is high whenever the count is zero.
module uart_bit_timer
   import uart_pkg::*;
(
   input  logic                    clk,
   input  logic                    srst,
   input  logic                    load_i,
   input  logic [UART_TIMER_W-1:0] load_val_i,
   output logic                    expire_o
);

   logic [UART_TIMER_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, MSB first, mid-bit sampling, single-entry output buffer
// with valid/ready handshake, frame-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic    CLK,
   input  logic    RESET,
   uart_rx_if.master bus
);

   localparam logic [UART_TIMER_W-1:0] HALF_BIT   = uart_timer_val(CLKS_PER_BIT / 2);
   localparam logic [UART_TIMER_W-1:0] FULL_BIT   = uart_timer_val(CLKS_PER_BIT - 1);
   localparam logic [UART_IDX_W-1:0]   LAST_IDX   = UART_IDX_W'(UART_DATA_BITS - 1);
   // At one clock per bit the detecting sample already is the start-bit centre.
   localparam logic                    SKIP_START = (CLKS_PER_BIT == 1);

   uart_state_e               state_q, state_d;
   logic [UART_IDX_W-1:0]     idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      valid_q, valid_d;
   logic                      frame_err_q, frame_err_d;
   logic                      overrun_q, overrun_d;

   logic                      tmr_load;
   logic [UART_TIMER_W-1:0]   tmr_val;
   logic                      tmr_expire;
   logic                      deliver;

   uart_bit_timer u_bit_timer (
      .clk        (CLK),
      .srst       (RESET),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      tmr_load    = 1'b0;
      tmr_val     = FULL_BIT;
      deliver     = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!bus.rx) begin
               idx_d    = '0;
               tmr_load = 1'b1;
               state_d  = SKIP_START ? DATA : START;
               tmr_val  = SKIP_START ? FULL_BIT : HALF_BIT;
            end
         end
         START: begin
            if (tmr_expire) begin
               if (!bus.rx) begin
                  state_d  = DATA;
                  tmr_load = 1'b1;
                  tmr_val  = FULL_BIT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (tmr_expire) begin
               shift_d[LAST_IDX - idx_q] = bus.rx;
               tmr_load = 1'b1;
               tmr_val  = FULL_BIT;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tmr_expire) begin
               if (bus.rx) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            if (bus.rx) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A completed byte replaces the buffer only if it is empty or being drained now.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (deliver) begin
         if (!valid_q || bus.ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && bus.ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.data      = data_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clock/bit, one at 16 clocks/bit.
module tb_uart_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1;
   logic rst16;

   uart_rx_if if1 ();
   uart_rx_if if16 ();

   uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
      .CLK   (clk),
      .RESET (rst1),
      .bus   (if1)
   );

   uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
      .CLK   (clk),
      .RESET (rst16),
      .bus   (if16)
   );

   int n_checks = 0;
   int n_errors = 0;

   int cyc      = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int both_cnt = 0;
   int acc_prev = 0;
   int acc_last = 0;

   logic [7:0] part_byte;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (if1.frame_err) fe_cnt <= fe_cnt + 1;
      if (if1.overrun) ov_cnt <= ov_cnt + 1;
      if (if1.frame_err && if1.overrun) both_cnt <= both_cnt + 1;
      if (if1.valid && if1.ready) begin
         acc_prev <= acc_last;
         acc_last <= cyc;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives start, 8 data bits MSB first and the stop bit at 1 clock/bit;
   // returns in cycle T+10. The line is left at the stop-bit level.
   task automatic send1(input logic [7:0] b, input logic stop_bit, input logic rdy_at_stop);
      $display("rx1  frame 0x%02h stop=%0b", b, stop_bit);
      if1.rx = 1'b0;
      tick();
      for (int i = 7; i >= 0; i--) begin
         if1.rx = b[i];
         tick();
      end
      if (rdy_at_stop) if1.ready = 1'b1;
      if1.rx = stop_bit;
      tick();
   endtask

   task automatic send16(input logic [7:0] b);
      $display("rx16 frame 0x%02h", b);
      if16.rx = 1'b0;
      repeat (16) tick();
      for (int i = 7; i >= 0; i--) begin
         if16.rx = b[i];
         repeat (16) tick();
      end
      if16.rx = 1'b1;
      repeat (16) tick();
   endtask

   initial begin
      rst1       = 1'b1;
      rst16      = 1'b1;
      if1.rx     = 1'b1;
      if1.ready  = 1'b1;
      if16.rx    = 1'b1;
      if16.ready = 1'b0;
      part_byte  = 8'h5A;
      repeat (3) tick();

      check_val("rst1_valid", {31'd0, if1.valid}, 32'd0);
      check_val("rst1_data", {24'd0, if1.data}, 32'h00);
      check_val("rst1_ferr", {31'd0, if1.frame_err}, 32'd0);
      check_val("rst1_ovr", {31'd0, if1.overrun}, 32'd0);
      check_val("rst16_valid", {31'd0, if16.valid}, 32'd0);
      check_val("rst16_data", {24'd0, if16.data}, 32'h00);

      rst1  = 1'b0;
      rst16 = 1'b0;
      repeat (3) tick();
      check_val("idle_ready_no_effect", {31'd0, if1.valid}, 32'd0);

      // Single frame 0xA5, valid exactly at T+10 for one cycle.
      send1(8'hA5, 1'b1, 1'b0);
      check_val("a5_valid", {31'd0, if1.valid}, 32'd1);
      check_val("a5_data", {24'd0, if1.data}, 32'hA5);
      tick();
      check_val("a5_valid_drop", {31'd0, if1.valid}, 32'd0);

      // Back-to-back frames with no idle cycle.
      send1(8'h3C, 1'b1, 1'b0);
      check_val("b2b_first_valid", {31'd0, if1.valid}, 32'd1);
      check_val("b2b_first_data", {24'd0, if1.data}, 32'h3C);
      send1(8'hFF, 1'b1, 1'b0);
      check_val("b2b_second_valid", {31'd0, if1.valid}, 32'd1);
      check_val("b2b_second_data", {24'd0, if1.data}, 32'hFF);
      tick();
      check_val("b2b_spacing", 32'(acc_last - acc_prev), 32'd10);
      check_val("no_err_so_far", 32'(fe_cnt + ov_cnt), 32'd0);

      // Framing error followed by a held-low line (break).
      send1(8'h81, 1'b0, 1'b0);
      check_val("ferr_pulse", {31'd0, if1.frame_err}, 32'd1);
      check_val("ferr_no_valid", {31'd0, if1.valid}, 32'd0);
      tick();
      check_val("ferr_one_cycle", {31'd0, if1.frame_err}, 32'd0);
      repeat (4) tick();
      if1.rx = 1'b1;
      repeat (2) tick();
      check_val("break_no_valid", {31'd0, if1.valid}, 32'd0);
      send1(8'h55, 1'b1, 1'b0);
      check_val("after_break_valid", {31'd0, if1.valid}, 32'd1);
      check_val("after_break_data", {24'd0, if1.data}, 32'h55);
      tick();

      // Overrun with ready low, then acceptance coinciding with delivery.
      if1.ready = 1'b0;
      send1(8'h12, 1'b1, 1'b0);
      check_val("ovr_first_data", {24'd0, if1.data}, 32'h12);
      check_val("ovr_first_no_pulse", {31'd0, if1.overrun}, 32'd0);
      send1(8'h34, 1'b1, 1'b0);
      check_val("ovr_pulse", {31'd0, if1.overrun}, 32'd1);
      check_val("ovr_data_kept", {24'd0, if1.data}, 32'h12);
      check_val("ovr_valid_kept", {31'd0, if1.valid}, 32'd1);
      send1(8'h56, 1'b1, 1'b1);
      check_val("same_cycle_data", {24'd0, if1.data}, 32'h56);
      check_val("same_cycle_valid", {31'd0, if1.valid}, 32'd1);
      check_val("same_cycle_no_ovr", {31'd0, if1.overrun}, 32'd0);
      tick();
      check_val("same_cycle_drain", {31'd0, if1.valid}, 32'd0);
      check_val("ferr_total", 32'(fe_cnt), 32'd1);
      check_val("ovr_total", 32'(ov_cnt), 32'd1);
      check_val("err_coincide", 32'(both_cnt), 32'd0);

      // 16 clocks/bit: a short low glitch must be rejected.
      $display("rx16 glitch 5 cycles low");
      if16.rx = 1'b0;
      repeat (5) tick();
      if16.rx = 1'b1;
      repeat (20) tick();
      check_val("glitch_no_valid", {31'd0, if16.valid}, 32'd0);
      send16(8'hC3);
      check_val("c3_valid", {31'd0, if16.valid}, 32'd1);
      check_val("c3_data", {24'd0, if16.data}, 32'hC3);
      check_val("c3_no_ferr", {31'd0, if16.frame_err}, 32'd0);
      if16.ready = 1'b1;
      tick();
      check_val("c3_drain", {31'd0, if16.valid}, 32'd0);
      if16.ready = 1'b0;

      // Reset in the middle of a frame, after data bit 4.
      $display("rx16 partial frame 0x%02h, reset after bit 4", part_byte);
      if16.rx = 1'b0;
      repeat (16) tick();
      for (int i = 7; i >= 4; i--) begin
         if16.rx = part_byte[i];
         repeat (16) tick();
      end
      if16.rx = 1'b1;
      rst16   = 1'b1;
      tick();
      check_val("midrst_valid", {31'd0, if16.valid}, 32'd0);
      check_val("midrst_data", {24'd0, if16.data}, 32'h00);
      rst16 = 1'b0;
      repeat (200) tick();
      check_val("midrst_no_delivery", {31'd0, if16.valid}, 32'd0);
      send16(8'h96);
      check_val("post_rst_valid", {31'd0, if16.valid}, 32'd1);
      check_val("post_rst_data", {24'd0, if16.data}, 32'h96);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: CLK cycles per serial bit period; legal range 1..1024.
REQ-002 Port CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-003 Port RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-004 Port rx  input  1  serial line; idle high, start bit 0, 8 data bits MSB first, stop bit 1.
REQ-005 Port data  output  8  received byte; valid only while valid=1.
REQ-006 Port valid  output  1  received byte held in output buffer.
REQ-007 Port ready  input  1  consumer accepts data on the cycle valid=1 and ready=1.
REQ-008 Port frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-009 Port overrun  output  1  one-cycle pulse: completed byte dropped because the buffer was still full.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK.
REQ-011 IDLE: on rx=0, go to START, load the bit timer with CLKS_PER_BIT/2 (integer division), and clear the bit index.
REQ-012 START: at timer expiry, rx=0 -> DATA with the timer at CLKS_PER_BIT-1; rx=1 -> IDLE (glitch, nothing reported); with CLKS_PER_BIT=1 the IDLE detection sample is the confirmation and START lasts 0 cycles.
REQ-013 DATA: at each timer expiry, sample rx into shift-register bit 7-index (MSB first) and increment the index; after the 8th sample go to STOP.
REQ-014 STOP: at timer expiry, rx=1 -> deliver byte (REQ-015) and go to IDLE; rx=0 -> pulse frame_err, discard the byte, and go to BREAK.
REQ-015 Delivery: if valid=0, or valid=1 and ready=1 in the same cycle, load data and set valid=1; otherwise keep the old data and valid=1, and pulse overrun.
REQ-016 BREAK: stay in BREAK until rx=1, then go to IDLE; a low line is never taken as a start bit.
REQ-017 Handshake: valid=1 and ready=1 with no simultaneous delivery -> valid=0 next cycle; data stays constant while valid=1 and not accepted.
REQ-018 For CLKS_PER_BIT=1, with the start bit on rx in cycle T, data bits in T+1..T+8 and stop in T+9, valid SHALL be 1 from cycle T+10.
REQ-019 A start bit immediately following a stop bit (no idle cycle) SHALL be received without loss.
REQ-020 ready while valid=0 SHALL have no effect.
REQ-021 frame_err and overrun SHALL never be high in the same cycle.

Reset
REQ-022 RESET=1 SHALL force IDLE, valid=0, data=0, frame_err=0, overrun=0, bit index=0 and timer=0 on the next edge, overriding all other inputs.
REQ-023 RESET mid-frame SHALL discard the partial byte; reception resumes with the next rx=0 seen in IDLE after RESET deasserts.

Structure
REQ-024 The shared package uart_pkg SHALL hold the FSM state enum, UART_DATA_BITS=8, and the bit-timer width (clog2 of the maximum CLKS_PER_BIT).
REQ-025 The bit timer SHALL be a sub-module uart_bit_timer (load value and start in; expiry pulse out); all other logic stays in uart_rx.

Verification
REQ-026 CLKS_PER_BIT=1, ready=1, rx frame 0,1,0,1,0,0,1,0,1,1 starting at T -> data=0xA5 and valid=1 at T+10 for one cycle; no error pulses.
REQ-027 Back-to-back 0x3C then 0xFF with no idle cycle between frames, ready=1 -> two deliveries 10 cycles apart, values 0x3C then 0xFF.
REQ-028 Frame 0x81 with stop bit 0, rx held low 5 more cycles then high -> frame_err pulse at T+10, valid stays 0, next 0x55 frame received correctly.
REQ-029 ready=0, frames 0x12 then 0x34 -> data stays 0x12, overrun pulse on the second completion; a third frame completing in the same cycle ready=1 is accepted -> data=0x56 with no overrun.
REQ-030 CLKS_PER_BIT=16, 0xC3 at 16 cycles/bit plus a 5-cycle rx=0 glitch beforehand -> glitch ignored, data=0xC3; RESET asserted after bit 4 of a following frame -> no delivery, valid=0, then the next frame is received correctly.
